// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM sample port: FSM state encoding,
// access kind, active-low control bundle and its idle value, default sizes.
package psram_pkg;

    localparam int DEF_DATA_W      = 12;
    localparam int DEF_RAM_W       = 16;
    localparam int DEF_ADDR_W      = 23;
    localparam int DEF_WAIT_CYCLES = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    // All PSRAM strobes are active low.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic adv_n;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '1;

    // Strobe pattern for a given state and access kind.
    function automatic ctrl_t ctrl_for(state_e st, op_e op);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            ST_SETUP: begin
                c.ce_n  = 1'b0;
                c.adv_n = 1'b0;
                c.ub_n  = 1'b0;
                c.lb_n  = 1'b0;
            end
            ST_ACCESS: begin
                c.ce_n = 1'b0;
                c.ub_n = 1'b0;
                c.lb_n = 1'b0;
                if (op == OP_WRITE) begin
                    c.we_n = 1'b0;
                end else begin
                    c.oe_n = 1'b0;
                end
            end
            ST_RECOVER: begin
                c.ce_n = 1'b0;
                c.ub_n = 1'b0;
                c.lb_n = 1'b0;
            end
            default: begin
                c = CTRL_IDLE;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/psram_access_timer.sv
// Loadable down-counter timing the strobe-low phase of a PSRAM access.
// Loaded with WAIT_CYCLES-1; 'last' is high on the final cycle of the phase.
import psram_pkg::*;

module psram_access_timer #(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic last
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, or decrement while running until terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/psram_sample_port.sv
// Single-word sample write/read port for the asynchronous 16-bit PSRAM,
// with independent write/read pointers, programmable end address and
// full/empty flags.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | strobes deasserted, bus released, requests sampled here
// SETUP   | CE#/ADV#/UB#/LB# low, address presented, write data driven
// ACCESS  | WE# (write) or OE# (read) low for WAIT_CYCLES cycles
// RECOVER | strobe released, write data held, RdValid, pointer update
import psram_pkg::*;

module psram_sample_port #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RAM_W       = DEF_RAM_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WrReq,
    input  logic              RdReq,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] EndAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              Busy,
    output logic              Full,
    output logic              Empty,
    inout  wire  [RAM_W-1:0]  RamData,
    output logic [ADDR_W-1:0] Address,
    output logic              ChipEnable,
    output logic              OutputEnable,
    output logic              WriteEnable,
    output logic              UpperByte,
    output logic              LowerByte,
    output logic              AddressValid
);

    state_e            state_q,    state_d;
    op_e               op_q,       op_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              full_q,     full_d;
    logic [RAM_W-1:0]  wdata_q,    wdata_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              drive_q,    drive_d;
    ctrl_t             ctrl_q,     ctrl_d;

    logic [ADDR_W-1:0] rd_next;
    logic              empty;
    logic              timer_load;
    logic              timer_last;

    assign empty = (wr_ptr_q == '0) && !full_q;

    psram_access_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk  (Clock),
        .rst  (Reset),
        .load (timer_load),
        .run  (state_q == ST_ACCESS),
        .last (timer_last)
    );

    // Next-state, pointer and capture logic; outputs are derived from the
    // next state so the strobes come straight from flops.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        full_d     = full_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        timer_load = 1'b0;
        rd_next    = rd_ptr_q + ADDR_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (WrReq && !full_q) begin
                    addr_d  = wr_ptr_q;
                    wdata_d = RAM_W'(WrData);
                    op_d    = OP_WRITE;
                    state_d = ST_SETUP;
                end else if (RdReq && !empty) begin
                    addr_d  = rd_ptr_q;
                    op_d    = OP_READ;
                    state_d = ST_SETUP;
                end else if (Clear) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    full_d   = 1'b0;
                end
            end
            ST_SETUP: begin
                timer_load = 1'b1;
                state_d    = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (timer_last) begin
                    state_d = ST_RECOVER;
                    if (op_q == OP_READ) begin
                        rd_data_d = RamData[DATA_W-1:0];
                    end
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
                if (op_q == OP_WRITE) begin
                    // The last usable word was just written: flag full and
                    // keep the pointer parked on it.
                    if (wr_ptr_q == EndAddr) begin
                        full_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end else begin
                    // Playback loops back to the start of recorded data.
                    rd_ptr_d = (rd_next == wr_ptr_q) ? '0 : rd_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ctrl_d     = ctrl_for(state_d, op_d);
        drive_d    = (state_d != ST_IDLE) && (op_d == OP_WRITE);
        rd_valid_d = (state_d == ST_RECOVER) && (op_d == OP_READ);
    end

    // State, pointer and registered-output flops with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WRITE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= '0;
            full_q     <= 1'b0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            drive_q    <= 1'b0;
            ctrl_q     <= CTRL_IDLE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_q     <= addr_d;
            full_q     <= full_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            drive_q    <= drive_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Upper bus bits carry only zero padding and are not returned on reads.
    if (RAM_W > DATA_W) begin : g_ram_hi
        logic unused_ram_hi;
        assign unused_ram_hi = ^RamData[RAM_W-1:DATA_W];
    end

    assign RamData      = drive_q ? wdata_q : {RAM_W{1'bz}};
    assign Address      = addr_q;
    assign RdData       = rd_data_q;
    assign RdValid      = rd_valid_q;
    assign Busy         = (state_q != ST_IDLE);
    assign Full         = full_q;
    assign Empty        = empty;
    assign ChipEnable   = ctrl_q.ce_n;
    assign OutputEnable = ctrl_q.oe_n;
    assign WriteEnable  = ctrl_q.we_n;
    assign UpperByte    = ctrl_q.ub_n;
    assign LowerByte    = ctrl_q.lb_n;
    assign AddressValid = ctrl_q.adv_n;

endmodule
